led_matrix_scan: RTL and testbench

//  Consumer end of the 36-bit glyph image bus: takes a 6x6 image (row r = img[6r+5:6r], bit 6r+5 = leftmost column)
//  and drives a row-multiplexed 6x6 LED matrix. Double-buffered (pending/active) so images swap only at frame

---
 rtl/led_matrix_scan_pkg.sv | 31 +++
 rtl/led_matrix_scan_if.sv | 18 +
 rtl/led_scan_timer.sv | 102 ++++++++++
 rtl/led_matrix_scan.sv | 117 +++++++++++
 tb/tb_led_matrix_scan.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_matrix_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_matrix_scan_pkg
//  Description : Shared matrix geometry, scan FSM encoding and row-slice
//                helper used by the LED scanner and the glyph encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_matrix_scan_pkg;

  localparam int MATRIX_DIM = 6;
  localparam int IMG_W      = MATRIX_DIM * MATRIX_DIM;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  // Row r of an image word: img[6r+5:6r], bit 6r+5 being the leftmost pixel.
  function automatic logic [MATRIX_DIM-1:0] row_slice(input logic [IMG_W-1:0] img,
                                                      input logic [2:0]       r);
    logic [MATRIX_DIM-1:0] s;
    s = '0;
    for (int i = 0; i < MATRIX_DIM; i++) begin
      if (r == 3'(i)) s = img[MATRIX_DIM*i +: MATRIX_DIM];
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_matrix_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_matrix_scan_if
//  Description : Glyph image bus (36-bit image word, valid/ready handshake).
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_matrix_scan_if;
  import led_matrix_scan_pkg::*;

  logic [IMG_W-1:0] img;
  logic             img_valid;
  logic             img_ready;

  modport master (output img, output img_valid, input  img_ready);
  modport slave  (input  img, input  img_valid, output img_ready);

endinterface
`default_nettype wire

// File: rtl/led_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : led_scan_timer
//  Description : Row-slot divider and row counter for the LED scanner.
//                Sequences IDLE/BLANK/ON, flags the frame wrap and emits a
//                registered frame_start pulse on entry to row 0 blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_scan_timer
  import led_matrix_scan_pkg::*;
#(
  parameter int ROW_DIV   = 2000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output scan_state_e state_next,
  output logic [2:0]  row_idx_next,
  output logic        in_on,
  output logic        wrap,
  output logic        frame_start
);

  localparam int             DIV_W      = $clog2(ROW_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(ROW_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYC - 1);
  localparam logic [2:0]       ROW_LAST   = 3'(MATRIX_DIM - 1);

  scan_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       row_idx_q, row_idx_d;
  logic             frame_start_q, frame_start_d;

  // State, divider and row counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      div_q         <= '0;
      row_idx_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      row_idx_q     <= row_idx_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Next-state: disable always wins and clears the counters.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    row_idx_d = row_idx_q;
    wrap      = 1'b0;
    if (!enable) begin
      state_d   = ST_IDLE;
      div_d     = '0;
      row_idx_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_BLANK;
          div_d     = '0;
          row_idx_d = '0;
        end
        ST_BLANK: begin
          div_d = div_q + DIV_W'(1);
          if (div_q == BLANK_LAST) state_d = ST_ON;
        end
        ST_ON: begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            state_d = ST_BLANK;
            if (row_idx_q == ROW_LAST) begin
              row_idx_d = '0;
              wrap      = 1'b1;
            end else begin
              row_idx_d = row_idx_q + 3'd1;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          div_d     = '0;
          row_idx_d = '0;
        end
      endcase
    end
    // Entering row 0 blanking happens only from IDLE or on the frame wrap.
    frame_start_d = (state_d == ST_BLANK) && (div_d == '0) && (row_idx_d == '0);
  end

  assign state_next   = state_d;
  assign row_idx_next = row_idx_d;
  assign in_on        = (state_q == ST_ON);
  assign frame_start  = frame_start_q;

endmodule
`default_nettype wire

// File: rtl/led_matrix_scan.sv
`default_nettype none
// ============================================================================
//  Module      : led_matrix_scan
//  Description : 6x6 row-multiplexed LED matrix driver. Double-buffered image
//                (pending/active, swapped only at frame wrap), per-row
//                blanking, PWM brightness on the column drive.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_matrix_scan
  import led_matrix_scan_pkg::*;
#(
  parameter int ROW_DIV        = 2000,
  parameter int BLANK_CYC      = 16,
  parameter int PWM_BITS       = 4,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_matrix_scan_if.slave      img_bus,
  input  logic [PWM_BITS-1:0]   brightness,
  input  logic                  enable,
  output logic [MATRIX_DIM-1:0] row,
  output logic [MATRIX_DIM-1:0] col,
  output logic                  frame_start
);

  // Inactive pin levels; XOR with these applies the pin polarity.
  localparam logic [MATRIX_DIM-1:0] ROW_OFF = {MATRIX_DIM{ROW_ACTIVE_LOW}};
  localparam logic [MATRIX_DIM-1:0] COL_OFF = {MATRIX_DIM{COL_ACTIVE_LOW}};

  scan_state_e           state_next;
  logic [2:0]            row_idx_next;
  logic                  in_on;
  logic                  wrap;

  logic [IMG_W-1:0]      active_q, active_d;
  logic [IMG_W-1:0]      pending_q, pending_d;
  logic                  pending_full_q, pending_full_d;
  logic [PWM_BITS-1:0]   pwm_q, pwm_d;
  logic [MATRIX_DIM-1:0] row_q, row_d;
  logic [MATRIX_DIM-1:0] col_q, col_d;
  logic                  lit;

  led_scan_timer #(
    .ROW_DIV   (ROW_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .state_next   (state_next),
    .row_idx_next (row_idx_next),
    .in_on        (in_on),
    .wrap         (wrap),
    .frame_start  (frame_start)
  );

  assign img_bus.img_ready = ~pending_full_q;

  // Image buffers: a full pending buffer moves to active only on the frame
  // wrap; a handshake can only land while pending is empty, so the two never
  // collide and a boundary-clock handshake waits for the following frame.
  always_comb begin
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    if (wrap && pending_full_q) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end else if (img_bus.img_valid && !pending_full_q) begin
      pending_d      = img_bus.img;
      pending_full_d = 1'b1;
    end
  end

  // PWM phase and pin values, computed from the state being entered so the
  // registered pins line up with the internal counters.
  always_comb begin
    pwm_d = pwm_q;
    if (!enable)    pwm_d = '0;
    else if (in_on) pwm_d = pwm_q + PWM_BITS'(1);

    lit   = (brightness == {PWM_BITS{1'b1}}) || (pwm_d < brightness);
    row_d = ROW_OFF;
    col_d = COL_OFF;
    if (state_next == ST_ON) begin
      row_d = (MATRIX_DIM'(1) << row_idx_next) ^ ROW_OFF;
      // col[c] shows image bit 6r+c, so col[5] carries the leftmost pixel.
      col_d = (row_slice(active_d, row_idx_next) & {MATRIX_DIM{lit}}) ^ COL_OFF;
    end
  end

  // Buffer, PWM and output pin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      pwm_q          <= '0;
      row_q          <= ROW_OFF;
      col_q          <= COL_OFF;
    end else begin
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      pwm_q          <= pwm_d;
      row_q          <= row_d;
      col_q          <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_matrix_scan
//  Description : Self-checking bench for led_matrix_scan. A cycle model
//                pushes expected pins into a scoreboard on every clock; the
//                pins are popped and compared on the falling edge. Directed
//                checks cover the buffer swap and blanking/enable scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_matrix_scan;
  import led_matrix_scan_pkg::*;

  localparam int ROW_DIV   = 20;
  localparam int BLANK_CYC = 4;
  localparam int PWM_BITS  = 2;
  localparam int FRAME     = 6 * ROW_DIV;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b0;
  logic [PWM_BITS-1:0] brightness = 2'd3;
  logic [5:0]          row;
  logic [5:0]          col;
  logic                frame_start;

  led_matrix_scan_if bus();

  led_matrix_scan #(
    .ROW_DIV        (ROW_DIV),
    .BLANK_CYC      (BLANK_CYC),
    .PWM_BITS       (PWM_BITS),
    .ROW_ACTIVE_LOW (1'b0),
    .COL_ACTIVE_LOW (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .img_bus     (bus),
    .brightness  (brightness),
    .enable      (enable),
    .row         (row),
    .col         (col),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        run;
    logic [6:0]  pos;   // position within the frame, 0..FRAME-1
    logic [1:0]  pwm;
    logic [35:0] act;
    logic [35:0] pend;
    logic        full;
  } ms_t;

  ms_t        ms;
  logic [13:0] sb[$];  // {row, col, frame_start, img_ready}

  function automatic ms_t step(ms_t s, logic en, logic v, logic [35:0] im);
    ms_t n = s;
    if (!en) begin
      n.run = 1'b0; n.pos = '0; n.pwm = '0;
    end else if (!s.run) begin
      n.run = 1'b1; n.pos = '0;
    end else begin
      if (int'(s.pos) % ROW_DIV >= BLANK_CYC) n.pwm = s.pwm + 2'd1;
      if (int'(s.pos) == FRAME - 1) begin
        n.pos = '0;
        if (s.full) begin n.act = s.pend; n.full = 1'b0; end
      end else begin
        n.pos = s.pos + 7'd1;
      end
    end
    if (v && !s.full) begin n.pend = im; n.full = 1'b1; end
    return n;
  endfunction

  function automatic logic [13:0] exp_of(ms_t o, ms_t n, logic [1:0] br);
    logic [5:0] r_exp, c_exp;
    logic       fs, lit;
    int         r;
    r_exp = '0; c_exp = '0;
    fs = n.run && (n.pos == '0) && (!o.run || int'(o.pos) == FRAME - 1);
    if (n.run && int'(n.pos) % ROW_DIV >= BLANK_CYC) begin
      r     = int'(n.pos) / ROW_DIV;
      r_exp = 6'(1 << r);
      lit   = (br == 2'd3) || (n.pwm < br);
      c_exp = lit ? n.act[6*r +: 6] : 6'd0;
    end
    return {r_exp, c_exp, fs, !n.full};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms <= '0;
      sb.delete();
      sb.push_back(14'h001);
    end else begin
      ms <= step(ms, enable, bus.img_valid, bus.img);
      sb.push_back(exp_of(ms, step(ms, enable, bus.img_valid, bus.img), brightness));
    end
  end

  always @(negedge clk) begin
    if (sb.size() != 0) check_val("pins", {row, col, frame_start, bus.img_ready}, sb.pop_front());
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_pos(input int p, input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 2*FRAME + 10; i++) begin
      @(negedge clk);
      if (ms.run && int'(ms.pos) == p) begin found = 1'b1; break; end
    end
    if (!found) check_val({tag, "_timeout"}, found, 1'b1);
  endtask

  task automatic send_img(input logic [35:0] im, input string tag, output logic fs_at_acc);
    logic ok = 1'b0;
    fs_at_acc = 1'b0;
    @(posedge clk); #1;
    bus.img = im; bus.img_valid = 1'b1;
    for (int i = 0; i < 4*FRAME; i++) begin
      @(negedge clk);
      if (bus.img_ready) begin ok = 1'b1; fs_at_acc = frame_start; break; end
    end
    @(posedge clk); #1;
    bus.img_valid = 1'b0;
    check_val({tag, "_accepted"}, ok, 1'b1);
  endtask

  task automatic count_lit(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (col != 6'd0) n++;
    end
  endtask

  localparam logic [35:0] IMG_A = {6'h12, 6'h33, 6'h0C, 6'h1E, 6'h21, 6'h3F};
  localparam logic [35:0] IMG_B = {6'h00, 6'h2D, 6'h3F, 6'h0C, 6'h21, 6'h21};
  localparam logic [35:0] IMG_C = {6'h3F, 6'h00, 6'h21, 6'h0C, 6'h33, 6'h1E};
  localparam logic [35:0] IMG_D = {6'h21, 6'h21, 6'h21, 6'h21, 6'h21, 6'h21};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fs_acc;
    int   n;
    bus.img = '0; bus.img_valid = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check_val("rst_row", row, 6'd0);
    check_val("rst_col", col, 6'd0);
    check_val("rst_fs", frame_start, 1'b0);
    check_val("rst_ready", bus.img_ready, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Image offered while IDLE is taken into pending.
    send_img(36'h0_0000_003F, "img0", fs_acc);
    @(negedge clk);
    check_val("ready_full", bus.img_ready, 1'b0);

    // Enable: frame_start, frame 1 still shows the reset (blank) image.
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); @(negedge clk);
    check_val("fs_enable", frame_start, 1'b1);
    repeat (5) @(negedge clk);
    check_val("f1_row", row, 6'b000001);
    check_val("f1_col", col, 6'b000000);
    wait_pos(3, "f2_blank");
    check_val("f2_blank_row", row, 6'b000000);
    wait_pos(5, "f2_on");
    check_val("f2_row", row, 6'b000001);
    check_val("f2_col", col, 6'b111111);
    check_val("f2_ready", bus.img_ready, 1'b1);

    // Back-to-back: B waits for the swap and is accepted just after it.
    send_img(IMG_A, "img_a", fs_acc);
    @(negedge clk);
    check_val("ab_ready", bus.img_ready, 1'b0);
    send_img(IMG_B, "img_b", fs_acc);
    check_val("b_after_swap", fs_acc, 1'b1);
    wait_pos(45, "a_frame");
    check_val("a_row2", col, 6'h1E);
    wait_pos(45, "b_frame");
    check_val("b_row2", col, 6'h0C);

    // Brightness with an all-ones image.
    send_img(36'hF_FFFF_FFFF, "img_ones", fs_acc);
    brightness = 2'd1;
    wait_pos(FRAME - 1, "br1_wrap");
    wait_pos(3, "br1");
    count_lit(16, n);
    check_val("br1_lit", n, 4);
    brightness = 2'd2;
    wait_pos(3, "br2");
    count_lit(16, n);
    check_val("br2_lit", n, 8);
    brightness = 2'd0;
    wait_pos(FRAME - 1, "br0");
    count_lit(FRAME, n);
    check_val("br0_lit", n, 0);
    brightness = 2'd3;

    // Enable dropped mid row 3, then restarted.
    wait_pos(3*ROW_DIV + 10, "en_drop");
    check_val("row3_on", row, 6'b001000);
    enable = 1'b0;
    @(negedge clk);
    check_val("drop_row", row, 6'd0);
    check_val("drop_col", col, 6'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); @(negedge clk);
    check_val("fs_reenable", frame_start, 1'b1);
    repeat (5) @(negedge clk);
    check_val("reen_row", row, 6'b000001);

    // Handshake on the boundary clock shows one frame later.
    wait_pos(FRAME - 1, "bnd");
    bus.img = IMG_C; bus.img_valid = 1'b1;
    @(posedge clk); #1 bus.img_valid = 1'b0;
    @(negedge clk);
    check_val("bnd_ready", bus.img_ready, 1'b0);
    wait_pos(5, "bnd_cur");
    check_val("bnd_cur_col", col, 6'h3F);
    wait_pos(5, "bnd_next");
    check_val("bnd_next_col", col, 6'h1E);

    // Async reset mid-ON with a pending image: flushed, active cleared.
    send_img(IMG_D, "img_d", fs_acc);
    wait_pos(25, "rst_mid");
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_val("rstmid_row", row, 6'd0);
    check_val("rstmid_col", col, 6'd0);
    check_val("rstmid_ready", bus.img_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    count_lit(2*FRAME + 4, n);
    check_val("rst_dark", n, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
